// File: rtl/add3_share_pkg.sv
// Shared types and helpers for the three-operand add sequencer.
package add3_share_pkg;

    localparam int W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Returns {found, index}: first set bit of valid searching upward from ptr+1, wrapping at n.
    function automatic logic [3:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr, input int n);
        logic [3:0] res;
        logic       found;
        logic [2:0] idx;
        res   = 4'b0;
        found = 1'b0;
        idx   = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            if (i <= n && !found) begin
                idx = 3'((int'(ptr) + i) % n);
                if (valid[idx]) begin
                    res   = {1'b1, idx};
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/add3_share_ctrl_if.sv
// Requester/response bus of the shared three-operand adder.
// Optional ADD3_SHARE_SAT_EN adds the rsp_ovf saturation flag.
interface add3_share_ctrl_if
    import add3_share_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int W       = W_DEFAULT,
    parameter int ID_W    = 3
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*W-1:0] req_a;
    logic [NUM_REQ*W-1:0] req_b;
    logic [NUM_REQ*W-1:0] req_c;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [W+1:0]         rsp_sum;
    logic [ID_W-1:0]      rsp_id;
`ifdef ADD3_SHARE_SAT_EN
    logic                 rsp_ovf;
`endif

    modport master (
        output req_valid, req_a, req_b, req_c, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_id
`ifdef ADD3_SHARE_SAT_EN
        , input rsp_ovf
`endif
    );

    modport slave (
        input  req_valid, req_a, req_b, req_c, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_id
`ifdef ADD3_SHARE_SAT_EN
        , output rsp_ovf
`endif
    );

endinterface

// File: rtl/add16_core.sv
// Combinational W-bit adder with carry in/out; single shared instance, interchangeable with the prefix-tree adder.
module add16_core
    import add3_share_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/add3_share_ctrl.sv
// Round-robin sequencer computing A+B+C in two passes on one shared adder.
// Optional ADD3_SHARE_SAT_EN saturates the result to W bits and flags rsp_ovf.
//   state | meaning
//   IDLE  | arbitrate requesters, latch operands on handshake
//   PASS1 | adder computes A+B into s1/c1
//   PASS2 | adder computes s1+C, result registered
//   DONE  | result presented until rsp_ready
module add3_share_ctrl
    import add3_share_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int W       = W_DEFAULT,
    parameter int ID_W    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    add3_share_ctrl_if.slave    bus,
    output logic                busy
);

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, b_q, c_q, s1_q;
    logic            c1_q;
    logic [ID_W-1:0] id_q, ptr_q;
    logic [W+1:0]    sum_q;
    logic [3:0]      pick;
    logic            gnt_found;
    logic [2:0]      gnt_idx;
    logic [W-1:0]    a_sel, b_sel, c_sel;
    logic [NUM_REQ-1:0] ready;
    logic [W-1:0]    add_a, add_b, add_sum;
    logic            add_cout;
    logic [1:0]      carry_sum;

    assign pick      = rr_pick(8'(bus.req_valid), 3'(ptr_q), NUM_REQ);
    assign gnt_found = pick[3];
    assign gnt_idx   = pick[2:0];

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        c_sel = '0;
        ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_found && gnt_idx == 3'(i)) begin
                a_sel = bus.req_a[i*W +: W];
                b_sel = bus.req_b[i*W +: W];
                c_sel = bus.req_c[i*W +: W];
                if (state_q == IDLE) ready[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_found) state_d = PASS1;
            PASS1:   state_d = PASS2;
            PASS2:   state_d = DONE;
            DONE:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Adder inputs are held at zero outside the two compute passes.
    always_comb begin
        add_a = '0;
        add_b = '0;
        case (state_q)
            PASS1: begin
                add_a = a_q;
                add_b = b_q;
            end
            PASS2: begin
                add_a = s1_q;
                add_b = c_q;
            end
            default: ;
        endcase
    end

    add16_core #(.W(W)) u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign carry_sum = {1'b0, c1_q} + {1'b0, add_cout};

`ifdef ADD3_SHARE_SAT_EN
    logic ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            s1_q  <= '0;
            c1_q  <= 1'b0;
            id_q  <= '0;
            ptr_q <= ID_W'(NUM_REQ - 1);
            sum_q <= '0;
`ifdef ADD3_SHARE_SAT_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (gnt_found) begin
                    a_q   <= a_sel;
                    b_q   <= b_sel;
                    c_q   <= c_sel;
                    id_q  <= ID_W'(gnt_idx);
                    ptr_q <= ID_W'(gnt_idx);
                end
                PASS1: begin
                    s1_q <= add_sum;
                    c1_q <= add_cout;
                end
                PASS2: begin
`ifdef ADD3_SHARE_SAT_EN
                    if (carry_sum != 2'b00) begin
                        sum_q <= {2'b00, {W{1'b1}}};
                        ovf_q <= 1'b1;
                    end else begin
                        sum_q <= {2'b00, add_sum};
                        ovf_q <= 1'b0;
                    end
`else
                    sum_q <= {carry_sum, add_sum};
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = (state_q == DONE);
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_id    = id_q;
`ifdef ADD3_SHARE_SAT_EN
    assign bus.rsp_ovf   = ovf_q;
`endif
    assign busy          = (state_q != IDLE);

endmodule
